// File: rtl/ghost_mover_if.sv
// Bus between a ghost behaviour block, its mover and the maze wall memory.
// The mover sits on the slave side; the behaviour block and the wall memory drive the master side.
interface ghost_mover_if #(
    parameter int X_W = 5,
    parameter int Y_W = 5
);
    logic           update;
    logic [1:0]     dirToMove;
    logic           wallRd;
    logic [X_W-1:0] wallAddrX;
    logic [Y_W-1:0] wallAddrY;
    logic           wallData;
    logic [X_W-1:0] ghostPosX;
    logic [Y_W-1:0] ghostPosY;
    logic           canMoveU;
    logic           canMoveR;
    logic           canMoveD;
    logic           canMoveL;
    logic           moved;
    logic           moveDone;
    logic           busy;

    modport master (
        output update, dirToMove, wallData,
        input  wallRd, wallAddrX, wallAddrY, ghostPosX, ghostPosY,
               canMoveU, canMoveR, canMoveD, canMoveL, moved, moveDone, busy
    );

    modport slave (
        input  update, dirToMove, wallData,
        output wallRd, wallAddrX, wallAddrY, ghostPosX, ghostPosY,
               canMoveU, canMoveR, canMoveD, canMoveL, moved, moveDone, busy
    );
endinterface

// File: rtl/ghost_mover.sv
// Holds one ghost's tile position, applies the requested step on update and
// re-probes the four neighbour tiles in the wall memory to refresh the canMove flags.
module ghost_mover #(
    parameter int GRID_W   = 28,
    parameter int GRID_H   = 31,
    parameter int X_W      = 5,
    parameter int Y_W      = 5,
    parameter int START_X  = 13,
    parameter int START_Y  = 11,
    parameter int TUNNEL_Y = 14
) (
    input  logic         clk,
    input  logic         reset,
    ghost_mover_if.slave bus
);
    typedef enum logic [2:0] {IDLE, P_U, P_R, P_D, P_L, P_LAST} state_e;

    localparam logic [X_W-1:0] X_LAST   = X_W'(GRID_W - 1);
    localparam logic [Y_W-1:0] Y_LAST   = Y_W'(GRID_H - 1);
    localparam logic [Y_W-1:0] Y_TUNNEL = Y_W'(TUNNEL_Y);
    localparam logic [X_W-1:0] X_ONE    = X_W'(1);
    localparam logic [Y_W-1:0] Y_ONE    = Y_W'(1);

    state_e         state_q, state_d;
    logic [X_W-1:0] pos_x_q, pos_x_d;
    logic [Y_W-1:0] pos_y_q, pos_y_d;
    logic [3:0]     can_q, can_d;        // {U, R, D, L}
    logic [2:0]     shadow_q, shadow_d;  // {U, R, D}; L lands straight in can_d
    logic           moved_q, moved_d;
    logic           done_q, done_d;
    logic           rd_prev_q;

    logic           rd;
    logic [X_W-1:0] addr_x;
    logic [Y_W-1:0] addr_y;
    logic           on_tunnel, up_ok, right_ok, down_ok, left_ok, open_tile;
    logic [X_W-1:0] left_x, right_x;
    logic [Y_W-1:0] up_y, down_y;

    assign on_tunnel = (pos_y_q == Y_TUNNEL);
    assign up_y      = pos_y_q - Y_ONE;
    assign down_y    = pos_y_q + Y_ONE;
    assign left_x    = (pos_x_q == '0)     ? X_LAST : pos_x_q - X_ONE;
    assign right_x   = (pos_x_q == X_LAST) ? '0     : pos_x_q + X_ONE;
    assign up_ok     = (pos_y_q != '0);
    assign down_ok   = (pos_y_q != Y_LAST);
    assign left_ok   = (pos_x_q != '0)     || on_tunnel;
    assign right_ok  = (pos_x_q != X_LAST) || on_tunnel;

    // A slot that issued no read (off-grid neighbour) always reads back as blocked.
    assign open_tile = rd_prev_q & ~bus.wallData;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned and infers a latch.
        state_d  = state_q;
        pos_x_d  = pos_x_q;
        pos_y_d  = pos_y_q;
        can_d    = can_q;
        shadow_d = shadow_q;
        moved_d  = moved_q;
        done_d   = 1'b0;
        rd       = 1'b0;
        addr_x   = '0;
        addr_y   = '0;
        case (state_q)
            IDLE: begin
                if (bus.update) begin
                    state_d = P_U;
                    moved_d = 1'b0;
                    case (bus.dirToMove)
                        2'b00: if (can_q[3]) begin pos_y_d = up_y;    moved_d = 1'b1; end
                        2'b01: if (can_q[2]) begin pos_x_d = right_x; moved_d = 1'b1; end
                        2'b10: if (can_q[1]) begin pos_y_d = down_y;  moved_d = 1'b1; end
                        default: if (can_q[0]) begin pos_x_d = left_x; moved_d = 1'b1; end
                    endcase
                end
            end
            P_U: begin
                rd      = up_ok;
                addr_x  = pos_x_q;
                addr_y  = up_y;
                state_d = P_R;
            end
            P_R: begin
                rd          = right_ok;
                addr_x      = right_x;
                addr_y      = pos_y_q;
                shadow_d[2] = open_tile;
                state_d     = P_D;
            end
            P_D: begin
                rd          = down_ok;
                addr_x      = pos_x_q;
                addr_y      = down_y;
                shadow_d[1] = open_tile;
                state_d     = P_L;
            end
            P_L: begin
                rd          = left_ok;
                addr_x      = left_x;
                addr_y      = pos_y_q;
                shadow_d[0] = open_tile;
                state_d     = P_LAST;
            end
            P_LAST: begin
                can_d   = {shadow_q, open_tile};
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: the state register resets into P_U so the flags get probed without an update;
    // the read port is therefore gated by reset below to stay quiet while reset is held.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= P_U;
            pos_x_q   <= X_W'(START_X);
            pos_y_q   <= Y_W'(START_Y);
            can_q     <= '0;
            shadow_q  <= '0;
            moved_q   <= 1'b0;
            done_q    <= 1'b0;
            rd_prev_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q   <= state_d;
            pos_x_q   <= pos_x_d;
            pos_y_q   <= pos_y_d;
            can_q     <= can_d;
            shadow_q  <= shadow_d;
            moved_q   <= moved_d;
            done_q    <= done_d;
            rd_prev_q <= rd;
        end
    end

    assign bus.wallRd    = rd & reset;
    assign bus.wallAddrX = reset ? addr_x : '0;
    assign bus.wallAddrY = reset ? addr_y : '0;
    assign bus.ghostPosX = pos_x_q;
    assign bus.ghostPosY = pos_y_q;
    assign {bus.canMoveU, bus.canMoveR, bus.canMoveD, bus.canMoveL} = can_q;
    assign bus.moved     = moved_q;
    assign bus.moveDone  = done_q;
    assign bus.busy      = (state_q != IDLE);
endmodule

// File: tb/tb_ghost_mover.sv
// Directed bench for ghost_mover: a wall-memory model answers reads, stimulus pushes
// hand-computed step results into a queue and a moveDone monitor pops and compares them.
module tb_ghost_mover;
    localparam int X_W = 5;
    localparam int Y_W = 5;
    localparam bit [3:0] ALL = 4'b1111;

    typedef struct { int x; int y; bit mv; bit [3:0] f; } exp_t;
    typedef struct { int cyc; int x; int y; } rd_t;

    logic clk;
    logic reset;
    ghost_mover_if #(.X_W(X_W), .Y_W(Y_W)) bus ();

    ghost_mover #(
        .GRID_W(28), .GRID_H(31), .X_W(X_W), .Y_W(Y_W),
        .START_X(13), .START_Y(11), .TUNNEL_Y(14)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    bit   wall_map [32][32];
    exp_t exp_q [$];
    rd_t  rd_log [$];
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   done_cnt = 0;
    int   done_cyc = 0;
    int   start_done = 0;
    int   acc_cyc = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Wall memory: data valid the cycle after the strobe; reads open when not strobed.
    always @(posedge clk) bus.wallData <= bus.wallRd ? wall_map[bus.wallAddrX][bus.wallAddrY] : 1'b0;

    always @(negedge clk)
        if (bus.wallRd) rd_log.push_back('{cyc, int'(bus.wallAddrX), int'(bus.wallAddrY)});

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic missed(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: event missing or timed out (got none, required one)", name);
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (bus.moveDone) begin
            done_cnt++;
            done_cyc = cyc;
            if (exp_q.size() == 0) begin
                missed("unexpected_moveDone");
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("posX",  int'(bus.ghostPosX), e.x);
                check("posY",  int'(bus.ghostPosY), e.y);
                check("moved", int'(bus.moved), int'(e.mv));
                check("canMove_URDL",
                      int'({bus.canMoveU, bus.canMoveR, bus.canMoveD, bus.canMoveL}), int'(e.f));
            end
        end
    end

    task automatic issue(input bit [1:0] dir, input int ex, input int ey, input bit emv, input bit [3:0] ef);
        for (int i = 0; i < 40 && bus.busy; i++) begin @(posedge clk); #1; end
        if (bus.busy) missed("wait_idle");
        exp_q.push_back('{ex, ey, emv, ef});
        rd_log.delete();
        start_done = done_cnt;
        bus.update    = 1'b1;
        bus.dirToMove = dir;
        @(posedge clk); #1;
        bus.update    = 1'b0;
        bus.dirToMove = ~dir;
        acc_cyc       = cyc;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 40 && done_cnt == start_done; i++) begin @(negedge clk); #1; end
        if (done_cnt == start_done) missed("moveDone_wait");
    endtask

    task automatic step(input bit [1:0] dir, input int ex, input int ey, input bit emv, input bit [3:0] ef);
        issue(dir, ex, ey, emv, ef);
        wait_done();
    endtask

    task automatic check_rd(input string name, input int idx, input int ex, input int ey);
        if (idx < rd_log.size()) begin
            check({name, "_x"}, rd_log[idx].x, ex);
            check({name, "_y"}, rd_log[idx].y, ey);
        end else begin
            missed(name);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: run exceeded its time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset         = 1'b0;
        bus.update    = 1'b0;
        bus.dirToMove = 2'b00;
        repeat (3) @(posedge clk);
        #1;
        check("rst_posX", int'(bus.ghostPosX), 13);
        check("rst_posY", int'(bus.ghostPosY), 11);
        check("rst_flags", int'({bus.canMoveU, bus.canMoveR, bus.canMoveD, bus.canMoveL}), 0);
        check("rst_moved", int'(bus.moved), 0);
        check("rst_moveDone", int'(bus.moveDone), 0);
        check("rst_wallRd", int'(bus.wallRd), 0);
        check("rst_addr", int'({bus.wallAddrX, bus.wallAddrY}), 0);

        // Reset release: probe without an update
        exp_q.push_back('{13, 11, 1'b0, ALL});
        rd_log.delete();
        start_done = done_cnt;
        reset = 1'b1;
        #1;
        check("busy_after_release", int'(bus.busy), 1);
        wait_done();
        check("release_reads", rd_log.size(), 4);
        check_rd("release_rdU", 0, 13, 10);
        check_rd("release_rdR", 1, 14, 11);
        check_rd("release_rdD", 2, 13, 12);
        check_rd("release_rdL", 3, 12, 11);
        if (rd_log.size() == 4) begin
            check("release_rd_span", rd_log[3].cyc - rd_log[0].cyc, 3);
            check("release_done_lat", done_cyc - rd_log[0].cyc, 5);
        end

        // Right step, position valid right after the accepting edge
        issue(2'b01, 14, 11, 1'b1, ALL);
        check("posX_after_edge", int'(bus.ghostPosX), 14);
        wait_done();
        check("step_done_lat", done_cyc - acc_cyc, 5);

        // Wall above (13,11): step left into it, then try up against it
        wall_map[13][10] = 1'b1;
        step(2'b11, 13, 11, 1'b1, 4'b0111);
        step(2'b00, 13, 11, 1'b0, 4'b0111);
        wall_map[13][10] = 1'b0;

        // Walk to the tunnel row and across to column 0
        for (int i = 1; i <= 3; i++) step(2'b10, 13, 11 + i, 1'b1, ALL);
        for (int i = 1; i <= 13; i++) step(2'b11, 13 - i, 14, 1'b1, ALL);

        // Tunnel wrap left from column 0
        step(2'b11, 27, 14, 1'b1, ALL);
        check("tunnel_reads", rd_log.size(), 4);
        check_rd("tunnel_rdU", 0, 27, 13);
        check_rd("tunnel_rdR", 1, 0, 14);
        check_rd("tunnel_rdD", 2, 27, 15);
        check_rd("tunnel_rdL", 3, 26, 14);

        // Wrap back right, walk to (5,1)
        step(2'b01, 0, 14, 1'b1, ALL);
        for (int i = 1; i <= 5; i++) step(2'b01, i, 14, 1'b1, ALL);
        for (int i = 1; i <= 13; i++) step(2'b00, 5, 14 - i, 1'b1, ALL);

        // Up onto row 0 with a second update pulsed while busy
        issue(2'b00, 5, 0, 1'b1, 4'b0111);
        @(posedge clk); #1;
        bus.update    = 1'b1;
        bus.dirToMove = 2'b10;
        @(posedge clk); #1;
        bus.update    = 1'b0;
        wait_done();
        check("row0_reads", rd_log.size(), 3);
        check_rd("row0_first_rd", 0, 6, 0);
        repeat (12) @(negedge clk);
        #1;
        check("single_moveDone", done_cnt - start_done, 1);
        check("row0_posY_hold", int'(bus.ghostPosY), 0);

        // Up at the top edge is blocked
        step(2'b00, 5, 0, 1'b0, 4'b0111);

        // Reset during P_D of a down step
        issue(2'b10, 5, 1, 1'b1, ALL);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        exp_q.delete();
        check("midrst_posX", int'(bus.ghostPosX), 13);
        check("midrst_posY", int'(bus.ghostPosY), 11);
        check("midrst_flags", int'({bus.canMoveU, bus.canMoveR, bus.canMoveD, bus.canMoveL}), 0);
        check("midrst_wallRd", int'(bus.wallRd), 0);
        check("midrst_moveDone", int'(bus.moveDone), 0);
        exp_q.push_back('{13, 11, 1'b0, ALL});
        start_done = done_cnt;
        @(posedge clk); #1;
        reset = 1'b1;
        wait_done();
        repeat (12) @(negedge clk);
        #1;
        check("post_reset_moveDone", done_cnt - start_done, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/ghost_mover.md
Name: ghost_mover

Overview:
- Sits directly downstream of each ghost's behaviour block.
- Holds the ghost's tile position and applies the dirToMove produced by that block on each update pulse.
- Probes the maze wall memory for the four neighbour tiles of the new position and returns the canMoveU/R/D/L flags the behaviour block uses for its next decision.
- One instance per ghost.

Parameters:
- GRID_W, 28, maze width in tiles.
- GRID_H, 31, maze height in tiles.
- X_W, 5, width of X coordinates.
- Y_W, 5, width of Y coordinates.
- START_X, 13, X tile loaded on reset.
- START_Y, 11, Y tile loaded on reset.
- TUNNEL_Y, 14, row on which horizontal movement wraps between column 0 and column GRID_W-1.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- update  in  1  single-cycle request to step the ghost once.
- dirToMove  in  2  requested direction: 00 up, 01 right, 10 down, 11 left.
- wallRd  out  1  wall memory read strobe.
- wallAddrX  out  X_W  wall memory X address.
- wallAddrY  out  Y_W  wall memory Y address.
- wallData  in  1  wall memory read data (1 = wall), valid the cycle after wallRd.
- ghostPosX  out  X_W  current ghost X tile.
- ghostPosY  out  Y_W  current ghost Y tile.
- canMoveU, canMoveR, canMoveD, canMoveL  out  1 each  neighbour tile open for the current position.
- moved  out  1  the last update changed position (valid with moveDone).
- moveDone  out  1  one-cycle pulse: position and canMove flags are consistent.
- busy  out  1  high while not in IDLE.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset values: ghostPosX=START_X, ghostPosY=START_Y, all canMove*=0, moved=0, moveDone=0, wallRd=0, addresses=0.
- On reset release the FSM enters P_U. This is the same probe sequence as a normal step without a move, so flags become valid without an update. busy=1 from reset release.
- FSM states: IDLE, P_U, P_R, P_D, P_L, P_LAST.
- IDLE with update=1, sampled at edge k:
  - If canMove flag for dirToMove = 1: position steps one tile (up = Y-1, down = Y+1, left = X-1, right = X+1) and moved<=1.
  - Otherwise position is unchanged and moved<=0.
  - State -> P_U.
- Tunnel wrap: on row TUNNEL_Y, left from X=0 goes to GRID_W-1, right from GRID_W-1 goes to 0.
- Probe pipeline:
  - P_U, P_R, P_D, P_L each drive wallRd=1 with the address of that neighbour.
  - Captures into shadow registers: U in P_R, R in P_D, D in P_L, L in P_LAST. canMove = NOT wallData.
  - P_LAST -> IDLE. At that edge (k+5) all four canMove outputs load from the shadow registers together. Outputs are never partially updated.
  - moveDone=1 for the single cycle k+5..k+6.
- Latency: update sampled at edge k -> position valid after edge k; flags and moveDone after edge k+5. Throughput: one step per 6 cycles.
- Off-grid neighbours (Y-1 at Y=0, Y+1 at GRID_H-1, X at an edge off the tunnel row):
  - wallRd=0 in that slot; the captured flag is forced to 0.
  - On the tunnel row the X neighbour wraps and is read normally.
- update while busy: ignored (dropped), no state change.
- update and moveDone in the same cycle: legal; FSM is in IDLE, so the update is accepted.
- dirToMove is sampled only at the accepting edge; later changes have no effect on that step.
- Reset asserted mid-probe: immediate return to reset values. Any partially captured shadow flags are discarded.

Test Plan:
- Reset release with wall memory all open around (13,11) -> busy=1, reads at (13,10),(14,11),(13,12),(12,11) on 4 consecutive cycles. moveDone pulse 5 cycles after the first read; all canMove=1.
- From (13,11), all open, update with dir=01 -> ghostPosX=14 the next cycle, moved=1, moveDone exactly 5 cycles after the update edge.
- Wall at (13,10), update with dir=00 from (13,11) -> position unchanged, moved=0, canMoveU stays 0 after re-probe.
- Position (0,TUNNEL_Y), dir=11, left open -> ghostPosX=GRID_W-1. Left-neighbour probe address is (GRID_W-2,TUNNEL_Y); right-neighbour address wraps to (0,TUNNEL_Y).
- Position (5,0) -> no wallRd in the P_U slot, canMoveU=0 regardless of wallData. A second update pulsed while busy -> ignored, exactly one moveDone.
- Reset asserted during P_D -> outputs return to START position and zero flags in the same cycle. After release a full probe sequence completes with one moveDone.
